// File: rtl/tcdm_bank_pkg.sv
// Shared types for the TCDM bank adapter: AMO opcodes and the AMO sequencing FSM states.
package tcdm_bank_pkg;

  typedef enum logic [2:0] {
    AMO_NONE = 3'd0,
    AMO_SWAP = 3'd1,
    AMO_ADD  = 3'd2,
    AMO_AND  = 3'd3,
    AMO_OR   = 3'd4,
    AMO_MAXU = 3'd5
  } amo_op_e;

  typedef enum logic {
    IDLE   = 1'b0,
    AMO_WR = 1'b1
  } state_e;

endpackage

// File: rtl/tcdm_amo_alu.sv
// Combinational AMO datapath: new value from the old memory word and the request operand.
module tcdm_amo_alu
  import tcdm_bank_pkg::*;
#(
  parameter int unsigned DataWidth = 32
) (
  input  amo_op_e              op_i,
  input  logic [DataWidth-1:0] old_i,
  input  logic [DataWidth-1:0] operand_i,
  output logic [DataWidth-1:0] new_o
);

  always_comb begin
    new_o = old_i;
    case (op_i)
      AMO_SWAP: new_o = operand_i;
      AMO_ADD:  new_o = old_i + operand_i;
      AMO_AND:  new_o = old_i & operand_i;
      AMO_OR:   new_o = old_i | operand_i;
      AMO_MAXU: new_o = (old_i > operand_i) ? old_i : operand_i;
      default:  new_o = old_i;
    endcase
  end

endmodule

// File: rtl/tcdm_bank_adapter.sv
// TCDM bank endpoint: req/gnt network port to a 1-cycle single-port SRAM, fixed-latency
// responses, and AMO read-modify-write that stalls the grant for one cycle.
module tcdm_bank_adapter
  import tcdm_bank_pkg::*;
#(
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned RespLat   = 1,
  parameter int unsigned AmoEn     = 1,
  localparam int unsigned AddrW    = $clog2(NumWords),
  localparam int unsigned BeW      = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  output logic                 gnt_o,
  input  logic [AddrW-1:0]     add_i,
  input  logic                 wen_i,
  input  logic [BeW-1:0]       be_i,
  input  logic [2:0]           amo_i,
  input  logic [DataWidth-1:0] wdata_i,
  output logic [DataWidth-1:0] rdata_o,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrW-1:0]     sram_addr_o,
  output logic [BeW-1:0]       sram_be_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  input  logic [DataWidth-1:0] sram_rdata_i
);

  state_e               state_q;
  logic [AddrW-1:0]     addr_q;
  logic [DataWidth-1:0] amo_new;
  logic                 rvld_d, rvld_q;
  logic [DataWidth-1:0] resp_s0;

  if (AmoEn != 0) begin : g_amo
    amo_op_e              op_q;
    logic [DataWidth-1:0] opnd_q;
    state_e               state_d;
    logic                 amo_go;

    assign amo_go = rst_ni && (state_q == IDLE) && req_i && !wen_i &&
                    (amo_i != AMO_NONE);

    always_comb begin
      state_d = state_q;
      case (state_q)
        IDLE:   if (amo_go) state_d = AMO_WR;
        AMO_WR: state_d = IDLE;
      endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q <= IDLE;
        op_q    <= AMO_NONE;
        addr_q  <= '0;
        opnd_q  <= '0;
      end else begin
        state_q <= state_d;
        if (amo_go) begin
          op_q   <= amo_op_e'(amo_i);
          addr_q <= add_i;
          opnd_q <= wdata_i;
        end
      end
    end

    // The read issued at grant lands on sram_rdata_i exactly in the AMO_WR cycle.
    tcdm_amo_alu #(.DataWidth(DataWidth)) i_alu (
      .op_i      (op_q),
      .old_i     (sram_rdata_i),
      .operand_i (opnd_q),
      .new_o     (amo_new)
    );
  end else begin : g_no_amo
    logic unused_amo;
    assign unused_amo = ^amo_i;
    assign state_q    = IDLE;
    assign addr_q     = '0;
    assign amo_new    = '0;
  end

  // Gating on rst_ni keeps gnt/SRAM quiet during reset and drops an in-flight AMO write.
  always_comb begin
    gnt_o        = 1'b0;
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = add_i;
    sram_be_o    = '1;
    sram_wdata_o = wdata_i;
    rvld_d       = 1'b0;
    if (rst_ni) begin
      case (state_q)
        IDLE: begin
          gnt_o      = req_i;
          sram_req_o = req_i;
          sram_we_o  = wen_i;
          if (wen_i) sram_be_o = be_i;
          rvld_d     = req_i & ~wen_i;
        end
        AMO_WR: begin
          sram_req_o   = 1'b1;
          sram_we_o    = 1'b1;
          sram_addr_o  = addr_q;
          sram_wdata_o = amo_new;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rvld_q <= 1'b0;
    else         rvld_q <= rvld_d;
  end

  assign resp_s0 = rvld_q ? sram_rdata_i : '0;

  if (RespLat <= 1) begin : g_no_pipe
    assign rdata_o = resp_s0;
  end else begin : g_pipe
    logic [RespLat-2:0][DataWidth-1:0] pipe_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        pipe_q <= '0;
      end else begin
        pipe_q[0] <= resp_s0;
        for (int i = 1; i < int'(RespLat) - 1; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign rdata_o = pipe_q[RespLat-2];
  end

endmodule

// File: tb/tb_tcdm_bank_adapter.sv
// Directed bench: three adapters (RespLat 1, RespLat 3, AMO disabled) share one stimulus
// stream, each backed by its own behavioural 1-cycle SRAM.
module tb_tcdm_bank_adapter;
  import tcdm_bank_pkg::*;

  localparam int NI = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req, wen;
  logic [3:0]        be;
  logic [2:0]        amo;
  logic [9:0]        addr;
  logic [31:0]       wdata;
  logic [NI-1:0]     gnt, sreq;
  logic [NI-1:0][31:0] rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int LAT = (g == 1) ? 3 : 1;
    localparam int AEN = (g == 2) ? 0 : 1;
    logic        swe;
    logic [9:0]  saddr;
    logic [3:0]  sbe;
    logic [31:0] swd, srd;
    logic [31:0] mem [1024];

    tcdm_bank_adapter #(
      .NumWords(1024), .DataWidth(32), .RespLat(LAT), .AmoEn(AEN)
    ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .req_i        (req),
      .gnt_o        (gnt[g]),
      .add_i        (addr),
      .wen_i        (wen),
      .be_i         (be),
      .amo_i        (amo),
      .wdata_i      (wdata),
      .rdata_o      (rdata[g]),
      .sram_req_o   (sreq[g]),
      .sram_we_o    (swe),
      .sram_addr_o  (saddr),
      .sram_be_o    (sbe),
      .sram_wdata_o (swd),
      .sram_rdata_i (srd)
    );

    always @(posedge clk) begin
      if (sreq[g]) begin
        if (swe) begin
          for (int b = 0; b < 4; b++)
            if (sbe[b]) mem[saddr][8*b +: 8] <= swd[8*b +: 8];
        end else begin
          srd <= mem[saddr];
        end
      end
    end
  end

  typedef struct {
    logic        req;
    logic        wen;
    logic [3:0]  be;
    logic [2:0]  amo;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic        gnt;
    logic [31:0] rd;
  } vec_t;

  vec_t v[$];

  function automatic vec_t mk(int r, int w, int b, int a, int ad, logic [31:0] d,
                              int g, logic [31:0] rd);
    vec_t m;
    m.req = r[0]; m.wen = w[0]; m.be = b[3:0]; m.amo = a[2:0];
    m.addr = ad[9:0]; m.wdata = d; m.gnt = g[0]; m.rd = rd;
    return m;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drv(input int r, input int w, input int b, input int a, input int ad,
                     input logic [31:0] d);
    req = r[0]; wen = w[0]; be = b[3:0]; amo = a[2:0]; addr = ad[9:0]; wdata = d;
  endtask

  task automatic idle_cyc();
    drv(0, 0, 0, 0, 0, 32'h0);
  endtask

  initial begin
    // row fields: req wen be amo addr wdata | gnt rdata(RespLat=1)
    v.push_back(mk(1,1,'hF,AMO_NONE, 5,32'hDEADBEEF, 1,32'h0));
    v.push_back(mk(1,0,0  ,AMO_NONE, 5,32'h0       , 1,32'h0));
    v.push_back(mk(1,1,'hF,AMO_NONE, 7,32'h11223344, 1,32'hDEADBEEF));
    v.push_back(mk(1,1,'h5,AMO_NONE, 7,32'hAABBCCDD, 1,32'h0));
    v.push_back(mk(1,0,0  ,AMO_NONE, 7,32'h0       , 1,32'h0));
    v.push_back(mk(1,1,'hF,AMO_NONE, 9,32'hFFFFFFFF, 1,32'h11BB33DD));
    v.push_back(mk(1,0,0  ,AMO_ADD , 9,32'h2       , 1,32'h0));
    v.push_back(mk(1,0,0  ,AMO_NONE, 9,32'h0       , 0,32'hFFFFFFFF));
    v.push_back(mk(1,0,0  ,AMO_NONE, 9,32'h0       , 1,32'h0));
    v.push_back(mk(0,0,0  ,AMO_NONE, 0,32'h0       , 0,32'h1));
    v.push_back(mk(1,1,'hF,AMO_NONE,11,32'h100     , 1,32'h0));
    v.push_back(mk(1,0,0  ,AMO_SWAP,11,32'hA1      , 1,32'h0));
    v.push_back(mk(1,0,0  ,AMO_SWAP,11,32'hA2      , 0,32'h100));
    v.push_back(mk(1,0,0  ,AMO_SWAP,11,32'hA2      , 1,32'h0));
    v.push_back(mk(1,0,0  ,AMO_SWAP,11,32'hA3      , 0,32'hA1));
    v.push_back(mk(1,0,0  ,AMO_SWAP,11,32'hA3      , 1,32'h0));
    v.push_back(mk(1,0,0  ,AMO_SWAP,11,32'hA4      , 0,32'hA2));
    v.push_back(mk(1,0,0  ,AMO_SWAP,11,32'hA4      , 1,32'h0));
    v.push_back(mk(1,0,0  ,AMO_NONE,11,32'h0       , 0,32'hA3));
    v.push_back(mk(1,0,0  ,AMO_NONE,11,32'h0       , 1,32'h0));
    v.push_back(mk(0,0,0  ,AMO_NONE, 0,32'h0       , 0,32'hA4));
    v.push_back(mk(0,0,0  ,AMO_NONE, 0,32'h0       , 0,32'h0));
    v.push_back(mk(1,1,'hF,AMO_ADD ,13,32'h55      , 1,32'h0));
    v.push_back(mk(1,0,0  ,AMO_NONE,13,32'h0       , 1,32'h0));
    v.push_back(mk(0,0,0  ,AMO_NONE, 0,32'h0       , 0,32'h55));
    v.push_back(mk(1,0,0  ,AMO_AND ,13,32'h0F      , 1,32'h0));
    v.push_back(mk(1,0,0  ,AMO_OR  ,13,32'hF0      , 0,32'h55));
    v.push_back(mk(1,0,0  ,AMO_OR  ,13,32'hF0      , 1,32'h0));
    v.push_back(mk(1,0,0  ,AMO_MAXU,13,32'h3       , 0,32'h05));
    v.push_back(mk(1,0,0  ,AMO_MAXU,13,32'h3       , 1,32'h0));
    v.push_back(mk(1,0,0  ,AMO_NONE,13,32'h0       , 0,32'hF5));
    v.push_back(mk(1,0,0  ,AMO_NONE,13,32'h0       , 1,32'h0));
    v.push_back(mk(0,0,0  ,AMO_NONE, 0,32'h0       , 0,32'hF5));
    v.push_back(mk(0,0,0  ,AMO_NONE, 0,32'h0       , 0,32'h0));
    v.push_back(mk(0,0,0  ,AMO_NONE, 0,32'h0       , 0,32'h0));
    v.push_back(mk(0,0,0  ,AMO_NONE, 0,32'h0       , 0,32'h0));

    // reset state, with a request pending to show the grant is held off
    rst_n = 1'b0;
    drv(1, 0, 0, AMO_NONE, 5, 32'h0);
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("reset gnt%0d", g),  32'(gnt[g]),  32'h0);
      chk($sformatf("reset rdata%0d", g), rdata[g],    32'h0);
      chk($sformatf("reset sreq%0d", g), 32'(sreq[g]), 32'h0);
    end
    idle_cyc();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < v.size(); i++) begin
      drv(32'(v[i].req), 32'(v[i].wen), 32'(v[i].be), 32'(v[i].amo), 32'(v[i].addr), v[i].wdata);
      @(negedge clk);
      chk($sformatf("row%0d gnt L1", i),   32'(gnt[0]), 32'(v[i].gnt));
      chk($sformatf("row%0d rdata L1", i), rdata[0],    v[i].rd);
      chk($sformatf("row%0d gnt L3", i),   32'(gnt[1]), 32'(v[i].gnt));
      chk($sformatf("row%0d rdata L3", i), rdata[1],    (i >= 2) ? v[i-2].rd : 32'h0);
      @(posedge clk); #1;
    end

    // reset during AMO_WR of ADD 1 on addr 3 (holding 10): write must be dropped
    drv(1, 1, 'hF, AMO_NONE, 3, 32'd10);
    @(posedge clk); #1;
    drv(1, 0, 0, AMO_ADD, 3, 32'd1);
    @(negedge clk);
    chk("rstamo grant", 32'(gnt[0]), 32'h1);
    @(posedge clk); #1;
    drv(1, 0, 0, AMO_NONE, 3, 32'h0);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("rstamo gnt in reset",  32'(gnt[0]),  32'h0);
    chk("rstamo rdata flushed", rdata[0],     32'h0);
    chk("rstamo sram idle",     32'(sreq[0]), 32'h0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstamo gnt follows req", 32'(gnt[0]), 32'h1);
    chk("rstamo rdata quiet",     rdata[0],    32'h0);
    @(posedge clk); #1;
    idle_cyc();
    @(negedge clk);
    chk("rstamo addr3 unchanged", rdata[0], 32'd10);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstamo rdata back to 0", rdata[0], 32'h0);
    @(posedge clk); #1;

    // AmoEn = 0 instance: MAXU acts as a plain read
    drv(1, 1, 'hF, AMO_NONE, 2, 32'd4);
    @(posedge clk); #1;
    drv(1, 0, 0, AMO_MAXU, 2, 32'd9);
    @(negedge clk);
    chk("noamo maxu gnt",   32'(gnt[2]), 32'h1);
    chk("noamo write resp", rdata[2],    32'h0);
    @(posedge clk); #1;
    drv(1, 0, 0, AMO_NONE, 2, 32'h0);
    @(negedge clk);
    chk("noamo next gnt",  32'(gnt[2]), 32'h1);
    chk("noamo maxu resp", rdata[2],    32'd4);
    @(posedge clk); #1;
    idle_cyc();
    @(negedge clk);
    chk("noamo addr2 unchanged", rdata[2], 32'd4);
    @(posedge clk); #1;
    @(negedge clk);
    chk("noamo rdata idle", rdata[2], 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tcdm_bank_adapter.md
Name: tcdm_bank_adapter

Overview:
- Slave-side endpoint of the TCDM interconnect; one instance per bank output port of the butterfly/xbar network.
- Accepts network requests (req/gnt handshake) and drives a single-port SRAM macro with 1-cycle read latency.
- Returns read data exactly RespLat cycles after grant, matching the network's fixed-latency response expectation.
- Adds atomic read-modify-write (AMO) execution via a small FSM that back-pressures through gnt_o.

Parameters:
- NumWords, 1024, words in the bank; power of 2.
- DataWidth, 32, word width; multiple of 8.
- RespLat, 1, cycles from grant to rdata_o; must be >= 1 and match the network's RespLat.
- AmoEn, 1, 1 enables AMO ops; 0 treats every amo_i as AMO_NONE.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  1  request from network
- gnt_o  out  1  grant to network
- add_i  in  $clog2(NumWords)  word address
- wen_i  in  1  1 = write, 0 = read
- be_i  in  DataWidth/8  byte enables (writes only)
- amo_i  in  3  amo_op_e (AMO_NONE, SWAP, ADD, AND, OR, MAXU)
- wdata_i  in  DataWidth  write data / AMO operand
- rdata_o  out  DataWidth  response data
- sram_req_o  out  1  SRAM enable
- sram_we_o  out  1  SRAM write enable
- sram_addr_o  out  $clog2(NumWords)  SRAM address
- sram_be_o  out  DataWidth/8  SRAM byte enables
- sram_wdata_o  out  DataWidth  SRAM write data
- sram_rdata_i  in  DataWidth  SRAM read data, valid 1 cycle after a read enable

Behaviour:
- Reset: FSM = IDLE; all pipeline registers and valid flags cleared; rdata_o = 0; gnt_o = 0 while in reset. sram_req_o = 0.
- IDLE, amo_i = AMO_NONE or wen_i = 1 (plain access): gnt_o = req_i combinationally; on req_i, drive the SRAM in the same cycle (sram_req_o = 1, we = wen_i, be = be_i for writes, all-ones for reads).
- IDLE, req_i with wen_i = 0 and amo_i != AMO_NONE (AmoEn = 1): gnt_o = 1; issue SRAM read; latch addr, op, operand; go to AMO_WR.
- AMO_WR (exactly 1 cycle): gnt_o = 0 regardless of req_i.
  - Compute new = f(sram_rdata_i, operand). ADD wraps modulo 2^DataWidth; MAXU is an unsigned compare; SWAP writes the operand.
  - Write new with full byte enables to the latched address, then return to IDLE.
- AMO back-pressure: a request presented during AMO_WR is held by the network and granted in the following IDLE cycle. Maximum sustained AMO throughput is 1 per 2 cycles.
- Response timing: for every grant at cycle t, rdata_o at cycle t+RespLat carries:
  - read: the SRAM word;
  - AMO: the old (pre-modify) value;
  - write: 0.
- rdata_o is 0 in every cycle with no response due.
- Response path:
  - A read-valid flag is registered alongside the SRAM access.
  - rdata_o = valid ? data : 0, through a RespLat-1 stage shift register placed after the SRAM output.
  - When RespLat = 1 there are no extra stages.
- Ordering: responses are strictly in grant order; the fixed latency means no tags are needed.
- Read-after-AMO to the same address in the next grant cycle returns the updated value, because the AMO write precedes it at the SRAM.
- Reset asserted mid-AMO: FSM returns to IDLE and the write is dropped; the response pipeline is flushed to 0.
- AmoEn = 0: AMO requests act as plain reads; the AMO_WR state and ALU are not generated.
- wen_i = 1 with amo_i != AMO_NONE: treated as a plain write; amo_i is ignored.

Decomposition:
- Package tcdm_bank_pkg holds:
  - the amo_op_e enum (3-bit) with its encodings: NONE = 0, SWAP = 1, ADD = 2, AND = 3, OR = 4, MAXU = 5;
  - the FSM state enum {IDLE, AMO_WR}.
- Sub-module tcdm_amo_alu: combinational (op, old, operand) -> new. It keeps the ALU separately testable and lets AmoEn = 0 drop it.
- The response shift register is inline.

Test Plan:
- Write then read: write 0xDEADBEEF to addr 5 with be = 4'hF, then read addr 5 → gnt_o = 1 on both; write response rdata_o = 0; read rdata_o = 0xDEADBEEF exactly RespLat cycles after the read grant (checked at RespLat = 1 and 3).
- Byte enables: addr 7 holds 0x11223344; write 0xAABBCCDD with be = 4'b0101 → a subsequent read returns 0x11BB33DD.
- AMO ADD with wrap: addr 9 holds 0xFFFFFFFF; ADD with operand 2 → response 0xFFFFFFFF; gnt_o = 0 in the next cycle; a later read returns 0x00000001.
- Back-to-back AMO stall: 4 consecutive SWAP requests held asserted → grants in cycles 0, 2, 4, 6; each response carries the previously swapped value.
- Reset mid-AMO: rst_ni asserted during AMO_WR of ADD 1 on addr 3 (value 10) → after reset gnt_o follows req_i immediately; addr 3 reads 10 and rdata_o stays 0 until the new grant's response.
- AmoEn = 0: a MAXU request on addr 2 (value 4, operand 9) → response 4; the next-cycle request is granted immediately; addr 2 still reads 4.
